num_display_scan: RTL and testbench
===================================

Name: num_display_scan

Overview:
Parameterised successor to the team's 4-digit numeric display driver. Converts a VALUE_W-bit binary value to BCD with a sequential double-dabble engine (one bit per clock). Time-multiplexes DIGITS seven-segment digits with a programmable refresh divider. Sits between any datapath register and the board's seven-segment anodes and segments.

Parameters:
VALUE_W, 16, width of the binary input.
DIGITS, 4, number of displayed digits (1..8); digit 0 is least significant.
REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2).
ACTIVE_LOW, 1, 1 = seg/an driven active-low; 0 = active-high.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
value  in  VALUE_W  binary number to display, sampled by the converter.
seg  out  7  segment drive {g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW.
an  out  DIGITS  one-hot digit enable, polarity set by ACTIVE_LOW.
digit_sel  out  3  index of the currently scanned digit.
bcd  out  4*DIGITS  last completed BCD result.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse when bcd/overflow update.
overflow  out  1  last converted value >= 10**DIGITS.

Behaviour:
- Reset (asynchronous, active-high): converter forced to IDLE; bcd=0, last_value=0, busy=0, done=0, overflow=0; digit_sel=0, refresh counter=0; seg and an inactive (all off).
- Converter FSM:
  - IDLE: if value != last_value, latch value into the shift register, clear the BCD accumulator, set count=VALUE_W, go to SHIFT, busy=1.
  - SHIFT: each cycle, add 3 to every accumulator nibble >=5, then shift {accumulator, shift reg} left by 1; decrement count; when count reaches 0, go to DONE.
  - DONE: bcd <= accumulator low 4*DIGITS bits; overflow <= (latched value >= 10**DIGITS); last_value <= latched value; done=1 for this cycle; busy=0; go to IDLE.
- The accumulator is internally wide enough for the full VALUE_W range; only the low DIGITS nibbles are exported.
- Latency: value change to bcd update is VALUE_W+2 cycles (IDLE compare, VALUE_W shifts, DONE).
- Changes to value during SHIFT are ignored. IDLE detects the mismatch after DONE and reconverts; bcd always reflects a complete, coherent sample.
- value==0 after reset: no conversion occurs; bcd=0, so the display shows 0.
- Reset mid-conversion aborts. After release, a nonzero value is reconverted from scratch.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and digit_sel advances; DIGITS-1 wraps to 0.
- seg and an are registered: they reflect digit_sel and bcd one cycle after either changes.
- Decode, active-high before the polarity inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Nibbles >9 cannot occur; decode them to blank (00).
- overflow=1: every digit shows a dash (40) in place of its decode.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: any digit above the most significant nonzero digit outputs seg blank (00 before inversion). Digit 0 is never blanked. an still cycles normally. Dashes on overflow are unaffected.
- Undefined: all DIGITS digits display their decode, including leading zeros.

Test Plan:
All scenarios use DIGITS=4, VALUE_W=16, REFRESH_DIV=4, ACTIVE_LOW=1.
1. Reset asserted asynchronously between clock edges -> seg=7F and an=F immediately; bcd=0, busy=0. After release, an=E and seg=40 (digit 0 shows "0") within 2 cycles.
2. value=100 -> busy high for 16 cycles; done pulses at cycle 18; bcd=0x0100, overflow=0.
3. value=9999 -> bcd=0x9999. Scan an sequence is E,D,B,7, each held 4 cycles; seg=10 on every digit; digit_sel wraps 3->0.
4. value=12345 -> overflow=1, bcd=0x2345, all four digits seg=3F (dash). Then value=42 -> overflow=0, bcd=0x0042.
5. value 100 then 42 at cycle 5 of SHIFT -> first done gives bcd=0x0100. Reconversion starts automatically; second done, 18 cycles later, gives bcd=0x0042. Reset pulsed during a third conversion -> bcd=0, and reconversion follows.
6. With LEADING_ZERO_BLANK_EN, value=7 -> digit 0 seg=78; digits 1-3 seg=7F (blank) while an still cycles. Without the macro, digits 1-3 seg=40.

Source files
------------

// File: rtl/num_display_scan_if.sv
// Bus between a datapath value register and the numeric display scanner.
// master: the side that owns the value being displayed.
// slave : the display scanner, which drives segments, anodes and status.
interface num_display_scan_if #(
    parameter int VALUE_W = 16,
    parameter int DIGITS  = 4
);
    logic [VALUE_W-1:0]  value;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic [2:0]          digit_sel;
    logic [4*DIGITS-1:0] bcd;
    logic                busy;
    logic                done;
    logic                overflow;

    modport master (
        output value,
        input  seg, an, digit_sel, bcd, busy, done, overflow
    );

    modport slave (
        input  value,
        output seg, an, digit_sel, bcd, busy, done, overflow
    );
endinterface

// File: rtl/num_display_scan.sv
// Binary-to-BCD numeric display driver.
// A sequential double-dabble engine converts the input one bit per clock,
// and DIGITS seven-segment digits are time-multiplexed with a programmable
// refresh divider. Optional build macro LEADING_ZERO_BLANK_EN blanks digits
// above the most significant nonzero digit (digit 0 is always shown).
module num_display_scan #(
    parameter int VALUE_W     = 16,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              reset,
    num_display_scan_if.slave disp
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Decimal digits needed for 2**VALUE_W: floor(VALUE_W*log10(2)) + 1.
    localparam int ACC_MIN = (VALUE_W * 30103) / 100000 + 1;
    localparam int ACC_N   = (ACC_MIN > DIGITS) ? ACC_MIN : DIGITS;
    localparam int ACC_W   = 4 * ACC_N;
    localparam int CNT_W   = $clog2(VALUE_W + 1);
    localparam int RCNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [63:0]       LIMIT   = pow10(DIGITS);
    localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [ACC_W-1:0] dd_adjust(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        for (int i = 0; i < ACC_N; i++) begin
            r[4*i +: 4] = (a[4*i +: 4] >= 4'd5) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
        end
        return r;
    endfunction

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles blank.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic [VALUE_W-1:0]  last_q, last_d;
    logic                load, step;

    logic [VALUE_W-1:0]  shift_q;
    logic [VALUE_W-1:0]  latched_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_adj;
    logic [CNT_W-1:0]    cnt_q;

    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic [2:0]          digit_sel_q, digit_sel_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          nib;
    logic [6:0]          seg_hi;
    logic [DIGITS-1:0]   an_hi;
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0]          msd;
`endif

    assign acc_adj = dd_adjust(acc_q);

    // Converter control registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

    // Converter FSM: compare in IDLE, VALUE_W shift steps, then publish.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (disp.value != last_q) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                bcd_d   = acc_q[4*DIGITS-1:0];
                ovf_d   = (64'(latched_q) >= LIMIT);
                last_d  = latched_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    // Conversion datapath; loaded before use, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_q   <= disp.value;
            latched_q <= disp.value;
            acc_q     <= '0;
            cnt_q     <= CNT_W'(VALUE_W);
        end else if (step) begin
            acc_q   <= {acc_adj[ACC_W-2:0], shift_q[VALUE_W-1]};
            shift_q <= shift_q << 1;
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    // Refresh divider and digit index.
    always_comb begin
        rcnt_d      = rcnt_q + RCNT_W'(1);
        digit_sel_d = digit_sel_q;
        if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
            rcnt_d      = '0;
            digit_sel_d = (digit_sel_q == 3'(DIGITS - 1)) ? 3'd0 : digit_sel_q + 3'd1;
        end
    end

    // Segment/anode decode for the digit currently selected.
    always_comb begin
        nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel_q == 3'(i)) nib = bcd_q[4*i +: 4];
        end
        seg_hi = ovf_q ? 7'h40 : seg7(nib);
`ifdef LEADING_ZERO_BLANK_EN
        msd = 3'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
        end
        if (!ovf_q && (digit_sel_q > msd)) seg_hi = 7'h00;
`endif
        an_hi = DIGITS'(1) << digit_sel_q;
        seg_d = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        an_d  = (ACTIVE_LOW != 0) ? ~an_hi : an_hi;
    end

    // Scan registers; segments and anodes are registered and start dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt_q      <= '0;
            digit_sel_q <= 3'd0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            rcnt_q      <= rcnt_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign disp.seg       = seg_q;
    assign disp.an        = an_q;
    assign disp.digit_sel = digit_sel_q;
    assign disp.bcd       = bcd_q;
    assign disp.busy      = busy_q;
    assign disp.done      = done_q;
    assign disp.overflow  = ovf_q;

endmodule

// File: tb/tb_num_display_scan.sv
// Bench for num_display_scan: DIGITS=4, VALUE_W=16, REFRESH_DIV=4, active-low.
// Expected conversions are queued when a value is driven and popped on done.
module tb_num_display_scan;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] HI_ZERO = 7'h7F;
`else
    localparam logic [6:0] HI_ZERO = 7'h40;
`endif

    logic clk;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    num_display_scan_if #(.VALUE_W(16), .DIGITS(4)) disp ();

    num_display_scan #(
        .VALUE_W(16),
        .DIGITS(4),
        .REFRESH_DIV(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .disp (disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_of(input int v);
        logic [15:0] r;
        int d;
        d = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    task automatic drive_value(input int v);
        exp_t e;
        disp.value = 16'(v);
        e.bcd = bcd_of(v);
        e.ovf = (v >= 10000);
        sb_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else e = '1;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (disp.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int act;
        reset = 1'b1;
        disp.value = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (disp.seg !== 7'h7F) begin n_fail++; $display("FAIL rst_hold_seg got %h want 7f", disp.seg); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (disp.an !== 4'hE) begin n_fail++; $display("FAIL post_rst_an got %h want e", disp.an); end
        n_cmp++; if (disp.seg !== 7'h40) begin n_fail++; $display("FAIL post_rst_seg got %h want 40", disp.seg); end
        repeat (5) @(negedge clk);
        n_cmp++; if (disp.an !== 4'hD) begin n_fail++; $display("FAIL pre_async_an got %h want d", disp.an); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (disp.seg !== 7'h7F) begin n_fail++; $display("FAIL async_seg got %h want 7f", disp.seg); end
        n_cmp++; if (disp.an !== 4'hF) begin n_fail++; $display("FAIL async_an got %h want f", disp.an); end
        n_cmp++; if (disp.digit_sel !== 3'd0) begin n_fail++; $display("FAIL async_sel got %0d want 0", disp.digit_sel); end
        n_cmp++; if (disp.bcd !== 16'h0000) begin n_fail++; $display("FAIL async_bcd got %h want 0000", disp.bcd); end
        n_cmp++; if (disp.busy !== 1'b0 || disp.done !== 1'b0 || disp.overflow !== 1'b0) begin
            n_fail++; $display("FAIL async_flags got %b%b%b want 000", disp.busy, disp.done, disp.overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (disp.an !== 4'hE) begin n_fail++; $display("FAIL rel_an got %h want e", disp.an); end
        n_cmp++; if (disp.seg !== 7'h40) begin n_fail++; $display("FAIL rel_seg got %h want 40", disp.seg); end
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (disp.busy !== 1'b0 || disp.done !== 1'b0) act++;
        end
        n_cmp++; if (act != 0) begin n_fail++; $display("FAIL zero_idle got %0d active cycles want 0", act); end
    endtask

    task automatic test_convert_100();
        exp_t e;
        int cyc;
        int busy_n;
        drive_value(100);
        busy_n = 0;
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (disp.busy === 1'b1) busy_n++;
            if (disp.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL lat_100 got %0d want 18", cyc); end
        n_cmp++; if (busy_n != 16) begin n_fail++; $display("FAIL busy_len got %0d want 16", busy_n); end
        pop_exp(e);
        n_cmp++; if (disp.bcd !== e.bcd) begin n_fail++; $display("FAIL bcd_100 got %h want %h", disp.bcd, e.bcd); end
        n_cmp++; if (disp.overflow !== e.ovf) begin n_fail++; $display("FAIL ovf_100 got %b want %b", disp.overflow, e.ovf); end
        @(negedge clk);
        n_cmp++; if (disp.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", disp.done); end
    endtask

    task automatic test_scan_9999();
        exp_t e;
        int cyc;
        int start;
        logic [3:0] prev_an;
        logic [3:0] want_an;
        drive_value(9999);
        wait_done(40, cyc);
        n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL lat_9999 got %0d want 18", cyc); end
        pop_exp(e);
        n_cmp++; if (disp.bcd !== e.bcd) begin n_fail++; $display("FAIL bcd_9999 got %h want %h", disp.bcd, e.bcd); end
        n_cmp++; if (disp.overflow !== e.ovf) begin n_fail++; $display("FAIL ovf_9999 got %b want %b", disp.overflow, e.ovf); end
        prev_an = disp.an;
        start = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (prev_an === 4'h7 && disp.an === 4'hE) begin
                start = 1;
                break;
            end
            prev_an = disp.an;
        end
        n_cmp++; if (start != 1) begin n_fail++; $display("FAIL scan_wrap got %0d want 1", start); end
        for (int i = 0; i <= 16; i++) begin
            case ((i / 4) % 4)
                0:       want_an = 4'hE;
                1:       want_an = 4'hD;
                2:       want_an = 4'hB;
                default: want_an = 4'h7;
            endcase
            n_cmp++; if (disp.an !== want_an) begin n_fail++; $display("FAIL scan_an[%0d] got %h want %h", i, disp.an, want_an); end
            n_cmp++; if (disp.seg !== 7'h10) begin n_fail++; $display("FAIL scan_seg[%0d] got %h want 10", i, disp.seg); end
            n_cmp++; if (disp.digit_sel !== 3'(((i + 1) / 4) % 4)) begin
                n_fail++; $display("FAIL scan_sel[%0d] got %0d want %0d", i, disp.digit_sel, ((i + 1) / 4) % 4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int cyc;
        int bad;
        logic [3:0] cov;
        drive_value(12345);
        wait_done(40, cyc);
        n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL lat_12345 got %0d want 18", cyc); end
        pop_exp(e);
        n_cmp++; if (disp.bcd !== e.bcd) begin n_fail++; $display("FAIL bcd_12345 got %h want %h", disp.bcd, e.bcd); end
        n_cmp++; if (disp.overflow !== e.ovf) begin n_fail++; $display("FAIL ovf_12345 got %b want %b", disp.overflow, e.ovf); end
        @(negedge clk);
        bad = 0;
        cov = '0;
        repeat (16) begin
            @(negedge clk);
            if (disp.seg !== 7'h3F) bad++;
            cov = cov | ~disp.an;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL dash_seg got %0d non-dash samples want 0", bad); end
        n_cmp++; if (cov !== 4'hF) begin n_fail++; $display("FAIL dash_cover got %h want f", cov); end
        drive_value(42);
        wait_done(40, cyc);
        n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL lat_42 got %0d want 18", cyc); end
        pop_exp(e);
        n_cmp++; if (disp.bcd !== e.bcd) begin n_fail++; $display("FAIL bcd_42 got %h want %h", disp.bcd, e.bcd); end
        n_cmp++; if (disp.overflow !== e.ovf) begin n_fail++; $display("FAIL ovf_42 got %b want %b", disp.overflow, e.ovf); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int cyc;
        int busy_n;
        drive_value(100);
        busy_n = 0;
        for (int k = 1; k <= 30 && busy_n < 5; k++) begin
            @(negedge clk);
            if (disp.busy === 1'b1) busy_n++;
        end
        drive_value(42);
        wait_done(40, cyc);
        n_cmp++; if (cyc != 13) begin n_fail++; $display("FAIL b2b_first_lat got %0d want 13", cyc); end
        pop_exp(e);
        n_cmp++; if (disp.bcd !== e.bcd) begin n_fail++; $display("FAIL b2b_first_bcd got %h want %h", disp.bcd, e.bcd); end
        wait_done(40, cyc);
        n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL b2b_second_lat got %0d want 18", cyc); end
        pop_exp(e);
        n_cmp++; if (disp.bcd !== e.bcd) begin n_fail++; $display("FAIL b2b_second_bcd got %h want %h", disp.bcd, e.bcd); end
        drive_value(9999);
        repeat (5) @(negedge clk);
        n_cmp++; if (disp.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_third_busy got %b want 1", disp.busy); end
        reset = 1'b1;
        sb_q.delete();
        #1;
        n_cmp++; if (disp.bcd !== 16'h0000) begin n_fail++; $display("FAIL abort_bcd got %h want 0000", disp.bcd); end
        n_cmp++; if (disp.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", disp.busy); end
        e.bcd = bcd_of(9999);
        e.ovf = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        reset = 1'b0;
        wait_done(40, cyc);
        n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL reconv_lat got %0d want 18", cyc); end
        pop_exp(e);
        n_cmp++; if (disp.bcd !== e.bcd) begin n_fail++; $display("FAIL reconv_bcd got %h want %h", disp.bcd, e.bcd); end
    endtask

    task automatic test_leading_digits();
        exp_t e;
        int cyc;
        logic [3:0] cov;
        logic [6:0] want;
        drive_value(7);
        wait_done(40, cyc);
        n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL lat_7 got %0d want 18", cyc); end
        pop_exp(e);
        n_cmp++; if (disp.bcd !== e.bcd) begin n_fail++; $display("FAIL bcd_7 got %h want %h", disp.bcd, e.bcd); end
        @(negedge clk);
        cov = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            want = (disp.an === 4'hE) ? 7'h78 : HI_ZERO;
            n_cmp++; if (disp.seg !== want) begin n_fail++; $display("FAIL lead_seg an=%h got %h want %h", disp.an, disp.seg, want); end
            cov = cov | ~disp.an;
        end
        n_cmp++; if (cov !== 4'hF) begin n_fail++; $display("FAIL lead_an_cover got %h want f", cov); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_convert_100();
        test_scan_9999();
        test_overflow();
        test_back_to_back();
        test_leading_digits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
